// File: rtl/lsu_ctrl.sv
// Load/store sequencer: IDLE -> REQ -> DONE, 3 cycles minimum per access, 2 for decode errors.
// Holds mem_req until mem_ready (bounded by TIMEOUT_CYC); stalls the core until done.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  lsunit,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0]  ERR_NONE  = 2'b00;
    localparam logic [1:0]  ERR_ALIGN = 2'b01;
    localparam logic [1:0]  ERR_ILL   = 2'b10;
    localparam logic [1:0]  ERR_TOUT  = 2'b11;
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  err_q;
    logic [31:0] ld_q;

    logic        legal;
    logic        misal;
    logic [3:0]  be_n;
    logic [31:0] lanes_n;
    logic [31:0] rshift;
    logic [15:0] rhalf;
    logic [31:0] ext;

    // Decode of the incoming control word, only consumed in IDLE
    always_comb begin
        legal = 1'b0;
        case (lsunit[2:0])
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~lsunit[3];
            default:                legal = 1'b0;
        endcase
        misal = (lsunit[1:0] == 2'b01 && addr[0]) ||
                (lsunit[1:0] == 2'b10 && addr[1:0] != 2'b00);
        case (lsunit[1:0])
            2'b00:   begin be_n = 4'b0001 << addr[1:0]; lanes_n = {4{wdata[7:0]}};  end
            2'b01:   begin be_n = 4'b0011 << addr[1:0]; lanes_n = {2{wdata[15:0]}}; end
            default: begin be_n = 4'b1111;              lanes_n = wdata;            end
        endcase
    end

    always_comb begin
        rshift = mem_rdata >> {off_q, 3'b000};
        rhalf  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ext = {{16{rhalf[15]}}, rhalf};
            3'b100:  ext = {24'd0, rshift[7:0]};
            3'b101:  ext = {16'd0, rhalf};
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= ERR_NONE;
            ld_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsunit[4]) begin
                        off_q   <= addr[1:0];
                        f3_q    <= lsunit[2:0];
                        we_q    <= lsunit[3];
                        waddr_q <= addr[31:2];
                        wdata_q <= lanes_n;
                        be_q    <= be_n;
                        cnt     <= '0;
                        if (!legal) begin
                            err_q <= ERR_ILL;
                            ld_q  <= '0;
                            state <= DONE;
                        end else if (misal) begin
                            err_q <= ERR_ALIGN;
                            ld_q  <= '0;
                            state <= DONE;
                        end else begin
                            err_q <= ERR_NONE;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    // mem_ready in the last counted cycle beats the timeout
                    if (mem_ready) begin
                        if (!we_q)
                            ld_q <= ext;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        err_q <= ERR_TOUT;
                        ld_q  <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is forced low while reset is held, even before the first edge
    assign stall        = rst_n & ((state == IDLE) ? lsunit[4] : (state == REQ));
    assign done         = rst_n & (state == DONE);
    assign lsu_err      = done & (err_q != ERR_NONE);
    assign lsu_err_code = done ? err_q : ERR_NONE;
    assign load_data    = rst_n ? ld_q : 32'd0;
    assign mem_req      = rst_n & (state == REQ);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = rst_n ? {waddr_q, 2'b00} : 32'd0;
    assign mem_wdata    = rst_n ? wdata_q : 32'd0;
    assign mem_be       = rst_n ? be_q : 4'd0;
endmodule
